n_set_cache_multi_policy_controller: RTL and testbench
======================================================

// Module: n_set_cache_multi_policy_controller
// PURPOSE
//  Per-set replacement controller for an N-way set-associative cache, selectable LRU/MRU/FIFO.
//  Holds a true age ordering per set. Hits update it. A miss produces a registered victim
//  address through a small FSM, then ages the filled way.
//  Sits beside the cache controller: consumes the hit/miss strobes, returns the replacement address.
// PARAMETERS
//  CACHE_BLOCK_CAPACITY  16  total cache blocks, power of 2
//  CACHE_SET_SIZE        4   ways per set (N_WAYS), power of 2, >=2, <=CACHE_BLOCK_CAPACITY
//  POLICY                0   0=LRU, 1=MRU, 2=FIFO; other values are an elaboration error
//  Derived: BW_CAP=CLOG2(capacity), BW_GRP=CLOG2(ways), BW_SET=BW_CAP-BW_GRP, N_SET=2**BW_SET
// PORTS
//  clock_i   in   1       single clock, rising edge
//  resetn_i  in   1       reset, asynchronous, active-low
//  hit_i     in   1       1-cycle strobe: addr_i way was referenced
//  miss_i    in   1       level: held high until done_o seen, then dropped
//  addr_i    in   BW_CAP  {way, set}; way ignored on miss
//  done_o    out  1       victim valid
//  addr_o    out  BW_CAP  {victim_way, set}
// BEHAVIOUR
//  Reset (async): age[s][w]=w for all s,w; state=IDLE; done_o=0; addr_o=0; pending hit cleared.
//  Age update touch(s,w): every way with age<age[s][w] increments; age[s][w]=0.
//   Ages stay a permutation of 0..N_WAYS-1 per set.
//  LRU and MRU: touch on hit and on fill. FIFO: touch on fill only; hits are ignored.
//  Victim: LRU/FIFO -> way with age N_WAYS-1; MRU -> way with age 0.
//  FSM:
//   IDLE: hit_i -> touch, stay.
//    miss_i -> latch set, go SEARCH. miss_i has priority if hit_i coincides; the hit goes to pending.
//   SEARCH (1 cycle): register victim way.
//    Go DONE; done_o=1 and addr_o={victim,set} from the next cycle.
//    Latency miss_i rise -> done_o = 2 cycles.
//   DONE: done_o, addr_o held stable while miss_i=1.
//    miss_i=0 -> touch(set,victim) (fill), done_o=0, go IDLE. addr_o keeps its last value.
//  hit_i in SEARCH/DONE: stored in one-entry pending register {set,way}.
//   A second hit overwrites it (last wins). It is applied in the cycle after returning to IDLE,
//   before any new miss is searched; a miss arriving then waits 1 cycle in IDLE.
//  hit_i with miss_i in DONE: illegal by protocol. The controller pends it; no assertion fires.
//  addr_i is ignored outside IDLE; the set is latched.
//  N_SET==1: BW_SET=0, there is no set field, and addr_o = victim way only.
//  Reset mid-SEARCH/DONE: all state is restored to reset values at once; the fill is not applied.
// CONFIGURATION
//  CACHE_POLICY_INVALID_FIRST_EN defined:
//   - adds a valid bit per way, cleared on reset and set on fill.
//   - SEARCH picks the lowest-index invalid way if one exists; otherwise it uses the policy victim.
//   - the fill to an invalid way still does touch().
//  Not defined: every way is treated as valid and there is no valid storage.
// STRUCTURE
//  Package cache_policy_pkg:
//   - POLICY_LRU/MRU/FIFO constants.
//   - FSM state encoding (IDLE/SEARCH/DONE).
//   - age-vector helper width function.
//  Sub-module set_age_tracker, one instance per set. It holds the ages (+valid) and performs touch().
//   Combinationally it outputs the policy victim and the first-invalid way.
//   The top holds the FSM, the pending-hit register, and the output registers.
// TESTING  (capacity 16, 4 ways: 4 sets, addr={way[1:0],set[1:0]})
//  1. Reset, LRU, miss set1 (addr_i=4'h1) -> done_o at +2 cycles, addr_o=4'hD (way3).
//     With _EN defined: addr_o=4'h1 (way0 invalid).
//  2. LRU, hits to set2 ways 0,1,2,3, then miss set2 -> addr_o=4'h2 (way0).
//     Drop miss, miss again -> addr_o=4'h6 (way1).
//  3. MRU, hit way2 set0 (4'h8), miss set0 -> addr_o=4'h8.
//  4. FIFO, hits way3 set3 x3, miss set3 -> addr_o=4'hF (hits ignored).
//     After the fill, the next miss gives 4'hB.
//  5. LRU, miss set1; during DONE, hit way3 set1 (4'hD) -> addr_o unchanged.
//     After the drop, the pending hit is applied; the next miss set1 -> addr_o=4'h5 (way1).
//  6. Reset asserted during DONE -> done_o=0 and addr_o=0 immediately, ages back to index.
//     The next miss set0 -> addr_o=4'hC.

Source files
------------

// File: rtl/cache_policy_pkg.sv
// Shared constants and types for the N-way replacement-policy controller.
// Optional build macro: CACHE_POLICY_INVALID_FIRST_EN (victim search prefers invalid ways).
package cache_policy_pkg;

    localparam int unsigned POLICY_LRU  = 0;
    localparam int unsigned POLICY_MRU  = 1;
    localparam int unsigned POLICY_FIFO = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Width of one set's packed age vector: one age field of clog2(ways) bits per way.
    function automatic int unsigned age_vec_width(input int unsigned n_ways);
        return n_ways * $clog2(n_ways);
    endfunction

endpackage

// File: rtl/n_set_cache_multi_policy_controller_set_age_tracker.sv
// Per-set age ordering (0 = most recent). touch() moves a way to age 0 and shifts
// younger ways up by one. Combinationally reports the policy victim.
// With CACHE_POLICY_INVALID_FIRST_EN defined it also keeps a valid bit per way and
// reports the lowest-index invalid way.
module set_age_tracker
    import cache_policy_pkg::*;
#(
    parameter int unsigned N_WAYS = 4,
    parameter int unsigned POLICY = POLICY_LRU,
    parameter int unsigned BW_GRP = $clog2(N_WAYS)
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_touch,
    input  logic [BW_GRP-1:0] i_way,
`ifdef CACHE_POLICY_INVALID_FIRST_EN
    input  logic              i_fill,
    output logic              o_inv_any,
    output logic [BW_GRP-1:0] o_inv_way,
`endif
    output logic [BW_GRP-1:0] o_victim
);

    localparam int unsigned       AGE_W      = age_vec_width(N_WAYS);
    localparam logic [BW_GRP-1:0] VICTIM_AGE = (POLICY == POLICY_MRU) ? '0 : BW_GRP'(N_WAYS - 1);

    logic [AGE_W-1:0]  r_age;
    logic [BW_GRP-1:0] w_ref_age;

    // Current age of the way being touched.
    always_comb begin
        w_ref_age = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (i_way == BW_GRP'(w)) w_ref_age = r_age[w*BW_GRP +: BW_GRP];
        end
    end

    // Age storage: reset to identity ordering, touch keeps it a permutation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int w = 0; w < N_WAYS; w++) r_age[w*BW_GRP +: BW_GRP] <= BW_GRP'(w);
        end else if (i_touch) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (i_way == BW_GRP'(w))
                    r_age[w*BW_GRP +: BW_GRP] <= '0;
                else if (r_age[w*BW_GRP +: BW_GRP] < w_ref_age)
                    r_age[w*BW_GRP +: BW_GRP] <= r_age[w*BW_GRP +: BW_GRP] + BW_GRP'(1);
            end
        end
    end

    // Policy victim: the unique way holding the victim age.
    always_comb begin
        o_victim = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (r_age[w*BW_GRP +: BW_GRP] == VICTIM_AGE) o_victim = BW_GRP'(w);
        end
    end

`ifdef CACHE_POLICY_INVALID_FIRST_EN
    logic [N_WAYS-1:0] r_valid;

    // Valid bits: set when a way is filled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_valid <= '0;
        else if (i_touch && i_fill)
            r_valid[i_way] <= 1'b1;
    end

    // Lowest-index invalid way (scan downwards so the lowest wins).
    always_comb begin
        o_inv_any = ~(&r_valid);
        o_inv_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w]) o_inv_way = BW_GRP'(w);
        end
    end
`endif

endmodule

// File: rtl/n_set_cache_multi_policy_controller.sv
// Replacement controller for an N-way set-associative cache (LRU / MRU / FIFO).
// Hits touch the set's age ordering; a miss searches a registered victim address,
// holds it until miss_i drops, then fills (touches) the victim way.
// Optional build macro: CACHE_POLICY_INVALID_FIRST_EN (prefer invalid ways as victims).
module n_set_cache_multi_policy_controller
    import cache_policy_pkg::*;
#(
    parameter int unsigned CACHE_BLOCK_CAPACITY = 16,
    parameter int unsigned CACHE_SET_SIZE       = 4,
    parameter int unsigned POLICY               = POLICY_LRU
)(
    input  logic                                    clock_i,
    input  logic                                    resetn_i,
    input  logic                                    hit_i,
    input  logic                                    miss_i,
    input  logic [$clog2(CACHE_BLOCK_CAPACITY)-1:0] addr_i,
    output logic                                    done_o,
    output logic [$clog2(CACHE_BLOCK_CAPACITY)-1:0] addr_o
);

    localparam int unsigned BW_CAP    = $clog2(CACHE_BLOCK_CAPACITY);
    localparam int unsigned BW_GRP    = $clog2(CACHE_SET_SIZE);
    localparam int unsigned BW_SET    = BW_CAP - BW_GRP;
    localparam int unsigned N_SET     = 32'd1 << BW_SET;
    localparam int unsigned SET_W     = (BW_SET == 0) ? 1 : BW_SET;
    localparam logic        HIT_TOUCH = (POLICY != POLICY_FIFO);

    if (POLICY > POLICY_FIFO) begin : g_bad_policy
        $error("POLICY must be 0 (LRU), 1 (MRU) or 2 (FIFO)");
    end

    state_e            r_state, w_next_state;
    logic [SET_W-1:0]  r_set, r_pend_set, w_in_set, w_touch_set;
    logic [BW_GRP-1:0] r_victim, r_pend_way, w_in_way, w_touch_way, w_sel_victim;
    logic              r_pend_vld, r_done;
    logic [BW_CAP-1:0] r_addr, w_out_addr;
    logic              w_touch_en, w_fill, w_pend_load, w_pend_apply, w_latch_set, w_capture;
    logic [BW_GRP-1:0] w_trk_victim [N_SET];
`ifdef CACHE_POLICY_INVALID_FIRST_EN
    logic [N_SET-1:0]  w_trk_inv_any;
    logic [BW_GRP-1:0] w_trk_inv_way [N_SET];
`endif

    assign w_in_way = addr_i[BW_CAP-1 -: BW_GRP];

    // Address split / compose; with a single set there is no set field.
    if (BW_SET > 0) begin : g_set_field
        assign w_in_set   = addr_i[SET_W-1:0];
        assign w_out_addr = {w_sel_victim, r_set};
    end else begin : g_no_set_field
        assign w_in_set   = '0;
        assign w_out_addr = w_sel_victim;
    end

    // One age tracker per set.
    for (genvar s = 0; s < N_SET; s++) begin : g_trk
        set_age_tracker #(
            .N_WAYS (CACHE_SET_SIZE),
            .POLICY (POLICY),
            .BW_GRP (BW_GRP)
        ) u_trk (
            .i_clk    (clock_i),
            .i_rst_n  (resetn_i),
            .i_touch  (w_touch_en && (w_touch_set == SET_W'(s))),
            .i_way    (w_touch_way),
`ifdef CACHE_POLICY_INVALID_FIRST_EN
            .i_fill   (w_fill),
            .o_inv_any(w_trk_inv_any[s]),
            .o_inv_way(w_trk_inv_way[s]),
`endif
            .o_victim (w_trk_victim[s])
        );
    end

    // Victim of the latched set, preferring an invalid way when that feature is built.
    always_comb begin
        w_sel_victim = '0;
        for (int s = 0; s < N_SET; s++) begin
            if (r_set == SET_W'(s)) begin
                w_sel_victim = w_trk_victim[s];
`ifdef CACHE_POLICY_INVALID_FIRST_EN
                if (w_trk_inv_any[s]) w_sel_victim = w_trk_inv_way[s];
`endif
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    // FSM next state: a pending hit is drained before a new miss is searched.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (!r_pend_vld && miss_i) w_next_state = ST_SEARCH;
            ST_SEARCH: w_next_state = ST_DONE;
            ST_DONE:   if (!miss_i) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // FSM control outputs: touch source selection, pending-hit and capture strobes.
    always_comb begin
        w_touch_en   = 1'b0;
        w_touch_set  = r_set;
        w_touch_way  = r_victim;
        w_fill       = 1'b0;
        w_pend_load  = 1'b0;
        w_pend_apply = 1'b0;
        w_latch_set  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_vld) begin
                    w_pend_apply = 1'b1;
                    w_touch_en   = HIT_TOUCH;
                    w_touch_set  = r_pend_set;
                    w_touch_way  = r_pend_way;
                    w_pend_load  = hit_i;
                end else if (miss_i) begin
                    w_latch_set  = 1'b1;
                    w_pend_load  = hit_i;
                end else if (hit_i) begin
                    w_touch_en   = HIT_TOUCH;
                    w_touch_set  = w_in_set;
                    w_touch_way  = w_in_way;
                end
            end
            ST_SEARCH: begin
                w_capture   = 1'b1;
                w_pend_load = hit_i;
            end
            ST_DONE: begin
                w_pend_load = hit_i;
                if (!miss_i) begin
                    w_touch_en = 1'b1;
                    w_fill     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: latched set, victim, pending hit and outputs.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_set      <= '0;
            r_victim   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_set <= '0;
            r_pend_way <= '0;
            r_done     <= 1'b0;
            r_addr     <= '0;
        end else begin
            if (w_latch_set) r_set <= w_in_set;
            if (w_capture) begin
                r_victim <= w_sel_victim;
                r_done   <= 1'b1;
                r_addr   <= w_out_addr;
            end else if (w_fill) begin
                r_done   <= 1'b0;
            end
            if (w_pend_load) begin
                r_pend_vld <= 1'b1;
                r_pend_set <= w_in_set;
                r_pend_way <= w_in_way;
            end else if (w_pend_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign done_o = r_done;
    assign addr_o = r_addr;

endmodule

// File: tb/tb_n_set_cache_multi_policy_controller.sv
// Self-checking bench: three controllers (LRU, MRU, FIFO) share one stimulus stream and
// are each compared against a transaction-level age model. Honours CACHE_POLICY_INVALID_FIRST_EN.
module tb_n_set_cache_multi_policy_controller;

    localparam int NP = 3;
    localparam int NS = 4;
    localparam int NW = 4;

    logic       clock_i  = 1'b0;
    logic       resetn_i = 1'b0;
    logic       hit_i    = 1'b0;
    logic       miss_i   = 1'b0;
    logic [3:0] addr_i   = 4'h0;
    logic [2:0] done_v;
    logic [3:0] addr_v [NP];

    int checks = 0;
    int errors = 0;

    int  age [NP][NS][NW];
    bit  vld [NP][NS][NW];
    int  got [NP];
    bit  pend_v;
    int  pend_s, pend_w;

    n_set_cache_multi_policy_controller #(.CACHE_BLOCK_CAPACITY(16), .CACHE_SET_SIZE(4), .POLICY(0)) u_lru (
        .clock_i(clock_i), .resetn_i(resetn_i), .hit_i(hit_i), .miss_i(miss_i),
        .addr_i(addr_i), .done_o(done_v[0]), .addr_o(addr_v[0]));
    n_set_cache_multi_policy_controller #(.CACHE_BLOCK_CAPACITY(16), .CACHE_SET_SIZE(4), .POLICY(1)) u_mru (
        .clock_i(clock_i), .resetn_i(resetn_i), .hit_i(hit_i), .miss_i(miss_i),
        .addr_i(addr_i), .done_o(done_v[1]), .addr_o(addr_v[1]));
    n_set_cache_multi_policy_controller #(.CACHE_BLOCK_CAPACITY(16), .CACHE_SET_SIZE(4), .POLICY(2)) u_fifo (
        .clock_i(clock_i), .resetn_i(resetn_i), .hit_i(hit_i), .miss_i(miss_i),
        .addr_i(addr_i), .done_o(done_v[2]), .addr_o(addr_v[2]));

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) begin
                    age[p][s][w] = w;
                    vld[p][s][w] = 1'b0;
                end
    endfunction

    // Referenced way becomes youngest; every younger way ages by one.
    function automatic void m_touch(input int p, input int s, input int w);
        int r;
        r = age[p][s][w];
        for (int v = 0; v < NW; v++) begin
            if (v == w)          age[p][s][v] = 0;
            else if (age[p][s][v] < r) age[p][s][v] = age[p][s][v] + 1;
        end
    endfunction

    function automatic int m_victim(input int p, input int s);
`ifdef CACHE_POLICY_INVALID_FIRST_EN
        for (int w = 0; w < NW; w++) if (!vld[p][s][w]) return w;
`endif
        for (int w = 0; w < NW; w++) begin
            if (p == 1 && age[p][s][w] == 0)      return w;
            if (p != 1 && age[p][s][w] == NW - 1) return w;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_hit(input logic [3:0] a);
        hit_i  = 1'b1;
        addr_i = a;
        tick();
        hit_i  = 1'b0;
        for (int p = 0; p < 2; p++) m_touch(p, int'(a[1:0]), int'(a[3:2]));
    endtask

    task automatic record_hit(input logic [3:0] a);
        hit_i  = 1'b1;
        addr_i = a;
        pend_v = 1'b1;
        pend_s = int'(a[1:0]);
        pend_w = int'(a[3:2]);
    endtask

    // mode 0: no hits during the miss; 1: directed hit (haddr) in first hold cycle; 2: random hits.
    task automatic do_miss(input logic [3:0] a, input bit coin, input int hold, input int mode,
                           input logic [3:0] haddr);
        int exp_w [NP];
        int s, lat;
        bit seen;
        s = int'(a[1:0]);
        for (int p = 0; p < NP; p++) exp_w[p] = m_victim(p, s);
        pend_v = 1'b0;
        miss_i = 1'b1;
        addr_i = a;
        hit_i  = 1'b0;
        if (coin) record_hit(a);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            tick();
            lat++;
            hit_i = 1'b0;
            if (lat == 1) check("done_early", 32'(done_v), 32'h0);
            if (done_v == 3'b111) seen = 1'b1;
            else if (mode == 2 && $urandom_range(1) == 1) record_hit(4'($urandom_range(15)));
        end
        check("miss_latency", 32'(lat), 32'd2);
        for (int p = 0; p < NP; p++) begin
            got[p] = int'(addr_v[p]);
            check($sformatf("victim_p%0d", p), 32'(addr_v[p]), 32'(exp_w[p] * 4 + s));
        end
        for (int h = 0; h < hold; h++) begin
            if (mode == 1 && h == 0) record_hit(haddr);
            else if (mode == 2 && $urandom_range(1) == 1) record_hit(4'($urandom_range(15)));
            tick();
            hit_i = 1'b0;
            check("hold_done", 32'(done_v), 32'h7);
            for (int p = 0; p < NP; p++)
                check($sformatf("hold_addr_p%0d", p), 32'(addr_v[p]), 32'(exp_w[p] * 4 + s));
        end
        miss_i = 1'b0;
        if (mode == 2 && $urandom_range(1) == 1) record_hit(4'($urandom_range(15)));
        tick();
        hit_i = 1'b0;
        check("drop_done", 32'(done_v), 32'h0);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("drop_addr_p%0d", p), 32'(addr_v[p]), 32'(exp_w[p] * 4 + s));
            m_touch(p, s, exp_w[p]);
            vld[p][s][exp_w[p]] = 1'b1;
            if (pend_v && p != 2) m_touch(p, pend_s, pend_w);
        end
        pend_v = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        m_reset();
        pend_v = 1'b0;
        tick();
        tick();
        check("reset_done", 32'(done_v), 32'h0);
        for (int p = 0; p < NP; p++) check("reset_addr", 32'(addr_v[p]), 32'h0);
        resetn_i = 1'b1;
        tick();

        // Cold miss on set 1.
        do_miss(4'h1, 1'b0, 1, 0, 4'h0);
`ifdef CACHE_POLICY_INVALID_FIRST_EN
        check("t1_lru", 32'(got[0]), 32'h1);
`else
        check("t1_lru", 32'(got[0]), 32'hD);
`endif
        // Hits to set 2 ways 0..3 then two misses.
        do_hit(4'h2); do_hit(4'h6); do_hit(4'hA); do_hit(4'hE);
        do_miss(4'h2, 1'b0, 0, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t2a_lru", 32'(got[0]), 32'h2);
`endif
        do_miss(4'h2, 1'b0, 2, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t2b_lru", 32'(got[0]), 32'h6);
`endif
        // Hit during DONE is pended and applied after the fill.
        do_miss(4'h1, 1'b0, 2, 1, 4'hD);
        do_miss(4'h1, 1'b0, 0, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t5_lru", 32'(got[0]), 32'h5);
`endif
        // MRU hit then miss on set 0.
        do_hit(4'h8);
        do_miss(4'h0, 1'b0, 1, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t3_mru", 32'(got[1]), 32'h8);
`endif
        // FIFO ignores hits.
        do_hit(4'hF); do_hit(4'hF); do_hit(4'hF);
        do_miss(4'h3, 1'b0, 0, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t4a_fifo", 32'(got[2]), 32'hF);
`endif
        do_miss(4'h3, 1'b0, 0, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t4b_fifo", 32'(got[2]), 32'hB);
`endif
        // Miss with a coincident hit on the same address.
        do_miss(4'h6, 1'b1, 1, 0, 4'h0);

        // Reset while in DONE.
        miss_i = 1'b1;
        addr_i = 4'h0;
        lat = 0;
        while (done_v != 3'b111 && lat < 8) begin
            tick();
            lat++;
        end
        check("t6_reach_done", 32'(done_v), 32'h7);
        resetn_i = 1'b0;
        #1;
        check("t6_rst_done", 32'(done_v), 32'h0);
        for (int p = 0; p < NP; p++) check("t6_rst_addr", 32'(addr_v[p]), 32'h0);
        miss_i = 1'b0;
        tick();
        tick();
        resetn_i = 1'b1;
        m_reset();
        tick();
        do_miss(4'h0, 1'b0, 0, 0, 4'h0);
`ifndef CACHE_POLICY_INVALID_FIRST_EN
        check("t6_lru", 32'(got[0]), 32'hC);
`endif

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(2) == 0)
                do_miss(4'($urandom_range(15)), bit'($urandom_range(1)), int'($urandom_range(3)), 2, 4'h0);
            else
                do_hit(4'($urandom_range(15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
